// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs format/opcode/register/funct/immediate fields into a 32-bit word
// through a two-stage valid/ready pipeline. Optional feature macro: INSTR_ENCODER_ERR_COUNT_EN.
module instruction_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_imm_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  function automatic logic [31:0] encode(
    input logic [2:0]         fmt,
    input logic [6:0]         op,
    input logic [4:0]         rd,
    input logic [2:0]         f3,
    input logic [4:0]         rs1,
    input logic [4:0]         rs2,
    input logic [6:0]         f7,
    input logic signed [31:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (fmt)
      FMT_R: w = {f7, rs2, rs1, f3, rd, op};
      FMT_I: w = {imm[11:0], rs1, f3, rd, op};
      FMT_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U: w = {imm[31:12], rd, op};
      FMT_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = '0;
    endcase
    return w;
  endfunction

  // An immediate is representable when sign-extending its field width reproduces the full value.
  function automatic logic range_err(
    input logic [2:0]         fmt,
    input logic signed [31:0] imm
  );
    logic signed [31:0] sx12;
    logic signed [31:0] sx13;
    logic signed [31:0] sx21;
    logic               e;
    sx12 = signed'({{20{imm[11]}}, imm[11:0]});
    sx13 = signed'({{19{imm[12]}}, imm[12:0]});
    sx21 = signed'({{11{imm[20]}}, imm[20:0]});
    e = 1'b0;
    case (fmt)
      FMT_R:        e = 1'b0;
      FMT_I, FMT_S: e = (imm != sx12);
      FMT_B:        e = imm[0] | (imm != sx13);
      FMT_U:        e = (imm[11:0] != 12'd0);
      FMT_J:        e = imm[0] | (imm != sx21);
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  logic                vld_p1;
  logic [2:0]          fmt_p1;
  logic [6:0]          opcode_p1;
  logic [4:0]          rd_p1;
  logic [2:0]          funct3_p1;
  logic [4:0]          rs1_p1;
  logic [4:0]          rs2_p1;
  logic [6:0]          funct7_p1;
  logic signed [31:0]  imm_p1;

  logic                vld_p2;
  logic [31:0]         instr_p2;
  logic                err_p2;

  logic                b_free;
  logic                a_free;
  logic                in_xfer;
  logic                out_xfer;
  logic [31:0]         enc_p1;
  logic                enc_err_p1;

  assign b_free   = !vld_p2 || out_ready;
  assign a_free   = !vld_p1 || b_free;
  assign in_ready = a_free;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p2 && out_ready;

  // Stage A: capture raw request fields
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (a_free) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) begin
      fmt_p1    <= in_fmt;
      opcode_p1 <= in_opcode;
      rd_p1     <= in_rd;
      funct3_p1 <= in_funct3;
      rs1_p1    <= in_rs1;
      rs2_p1    <= in_rs2;
      funct7_p1 <= in_funct7;
      imm_p1    <= signed'(in_imm);
    end
  end

  always_comb begin
    enc_p1     = encode(fmt_p1, opcode_p1, rd_p1, funct3_p1, rs1_p1, rs2_p1, funct7_p1, imm_p1);
    enc_err_p1 = range_err(fmt_p1, imm_p1);
  end

  // Stage B: encoded word and error flag, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      instr_p2 <= '0;
      err_p2   <= 1'b0;
    end else if (b_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        instr_p2 <= enc_p1;
        err_p2   <= enc_err_p1;
      end
    end
  end

  assign out_valid   = vld_p2;
  assign out_instr   = instr_p2;
  assign out_imm_err = err_p2;

`ifdef INSTR_ENCODER_ERR_COUNT_EN
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_xfer && err_p2) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign err_count = cnt;
`else
  logic unused_xfer;
  assign unused_xfer = out_xfer;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vectors, a field-arithmetic reference model with an
// in-order expectation queue, and literal checks on the documented example encodings.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_imm_err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  instruction_encoder #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_imm_err(out_imm_err), .err_count(err_count)
  );

`ifdef INSTR_ENCODER_ERR_COUNT_EN
  localparam logic [7:0] CNT_AFTER4 = 8'd4;
  localparam logic [7:0] CNT_SAT    = 8'd255;
`else
  localparam logic [7:0] CNT_AFTER4 = 8'd0;
  localparam logic [7:0] CNT_SAT    = 8'd0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: word built with shifts/masks, range judged on the numeric value of the immediate.
  function automatic logic [32:0] model(input bit [31:0] fmt, input bit [31:0] op,
                                        input bit [31:0] rd, input bit [31:0] f3,
                                        input bit [31:0] rs1, input bit [31:0] rs2,
                                        input bit [31:0] f7, input bit [31:0] imm);
    bit [31:0] w;
    bit        e;
    longint    s;
    s = longint'($signed(imm));
    w = 0;
    e = 0;
    case (fmt)
      0: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      2: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
          | ((imm & 32'h1F) << 7) | op;
        e = (s < -2048) || (s > 2047);
      end
      3: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
          | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | op;
        e = imm[0] || (s < -4096) || (s > 4095);
      end
      4: begin
        w = (imm & 32'hFFFFF000) | (rd << 7) | op;
        e = (imm & 32'hFFF) != 0;
      end
      5: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e = imm[0] || (s < -1048576) || (s > 1048575);
      end
      default: begin
        w = 0;
        e = 1;
      end
    endcase
    return {e, w};
  endfunction

  logic [32:0] q[$];
  logic [7:0]  exp_cnt;
  logic        hold;
  logic [32:0] held;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 8'd0;
      hold    = 1'b0;
    end else begin
      chk("err_count", err_count, exp_cnt);
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_word", {out_imm_err, out_instr}, held);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: actual=%0h required=none", out_instr);
        end else begin
          chk("out_word", {out_imm_err, out_instr}, q[0]);
          if (out_ready) begin
`ifdef INSTR_ENCODER_ERR_COUNT_EN
            if (q[0][32] && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
`endif
            void'(q.pop_front());
          end
        end
      end
      hold = out_valid && !out_ready;
      held = {out_imm_err, out_instr};
      if (in_valid && in_ready)
        q.push_back(model(in_fmt, in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns just after the edge that accepted it; in_valid stays high.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [6:0] f7, input logic [31:0] imm);
    bit ok;
    in_fmt = f; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = r1; in_rs2 = r2; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: actual=in_ready_low required=accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = 0; in_opcode = 0; in_rd = 0; in_funct3 = 0;
    in_rs1 = 0; in_rs2 = 0; in_funct7 = 0; in_imm = 0;

    chk("model_addi", model(1, 'h13, 1, 0, 0, 0, 0, 5), {1'b0, 32'h00500093});
    chk("model_beq", model(3, 'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC), {1'b0, 32'hFE000EE3});
    chk("model_jal", model(5, 'h6F, 1, 0, 0, 0, 0, 32'h800), {1'b0, 32'h001000EF});
    chk("model_i2048", model(1, 'h13, 1, 0, 0, 0, 0, 2048), {1'b1, 32'h80000093});
    chk("model_fmt7", model(7, 'h13, 1, 0, 0, 0, 0, 0), {1'b1, 32'h0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_imm_err", out_imm_err, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);

    // ADDI latency and encoding
    sync();
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    idle();
    @(negedge clk);
    chk("addi_lat1", out_valid, 1'b0);
    @(negedge clk);
    chk("addi_lat2", out_valid, 1'b1);
    chk("addi_word", out_instr, 32'h00500093);
    chk("addi_err", out_imm_err, 1'b0);

    // back-to-back SW then BEQ
    sync();
    send(2, 7'h23, 0, 2, 1, 2, 0, 32'd8);
    send(3, 7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC);
    idle();
    @(negedge clk);
    chk("sw_word", {out_valid, out_instr}, {1'b1, 32'h0020A423});
    @(negedge clk);
    chk("beq_word", {out_valid, out_instr}, {1'b1, 32'hFE000EE3});

    // JAL then LUI
    sync();
    send(5, 7'h6F, 1, 0, 0, 0, 0, 32'h800);
    send(4, 7'h37, 5, 0, 0, 0, 0, 32'h12345000);
    idle();
    @(negedge clk);
    chk("jal_word", {out_valid, out_instr}, {1'b1, 32'h001000EF});
    @(negedge clk);
    chk("lui_word", {out_valid, out_instr}, {1'b1, 32'h123452B7});

    // range errors, one at a time
    sync(); send(1, 7'h13, 1, 0, 0, 0, 0, 32'd2048); idle();
    repeat (2) @(negedge clk);
    chk("err_i2048", {out_valid, out_imm_err}, 2'b11);
    sync(); send(3, 7'h63, 0, 0, 0, 0, 0, 32'd3); idle();
    repeat (2) @(negedge clk);
    chk("err_b_odd", {out_valid, out_imm_err}, 2'b11);
    sync(); send(4, 7'h37, 5, 0, 0, 0, 0, 32'h1); idle();
    repeat (2) @(negedge clk);
    chk("err_u_low", {out_valid, out_imm_err}, 2'b11);
    sync(); send(7, 7'h13, 1, 0, 0, 0, 0, 32'd0); idle();
    repeat (2) @(negedge clk);
    chk("err_fmt7", {out_valid, out_imm_err, out_instr}, {2'b11, 32'h0});
    @(negedge clk);
    chk("err_count_4", err_count, CNT_AFTER4);

    // saturation
    sync();
    for (int i = 0; i < 300; i++) send(7, 7'h0, 0, 0, 0, 0, 0, 32'd0);
    idle();
    repeat (4) @(negedge clk);
    chk("err_count_sat", err_count, CNT_SAT);

    // backpressure
    sync();
    out_ready = 1'b0;
    send(0, 7'h33, 3, 0, 1, 2, 7'h20, 32'd0);
    send(1, 7'h13, 2, 0, 3, 0, 0, 32'hFFFFFFFF);
    fork
      send(2, 7'h23, 0, 2, 4, 5, 0, 32'hFFFFF800);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 1'b0);
          chk("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle();
    repeat (4) @(negedge clk);
    chk("bp_drained", q.size(), 0);

    // reset with both stages full
    sync();
    out_ready = 1'b0;
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd7);
    send(1, 7'h13, 2, 0, 0, 0, 0, 32'd9);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_err_count", err_count, 8'd0);
    chk("mrst_in_ready", in_ready, 1'b1);
    sync();
    send(1, 7'h13, 1, 0, 0, 0, 0, 32'd5);
    idle();
    repeat (2) @(negedge clk);
    chk("mrst_addi", {out_valid, out_instr}, {1'b1, 32'h00500093});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the core's immediate decode path: packs RV32I instruction fields (format, opcode, registers, functs, 32-bit immediate) into a 32-bit instruction word.
- Used by the debug program-buffer injector and the boot-stub generator to build instructions at run time.
- Two-stage valid/ready pipeline; checks that each immediate is representable in its format and flags violations.

Parameters:
- ERR_CNT_W, 8, width of the saturating immediate-error counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept request
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  input  7  instr[6:0]
- in_rd  input  5  destination register
- in_funct3  input  3  funct3
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct7  input  7  funct7 (R only)
- in_imm  input  32  byte-offset/value immediate, as the decoder would produce it
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded instruction
- out_imm_err  output  1  immediate unrepresentable, or illegal fmt
- err_count  output  ERR_CNT_W  saturating count of accepted words with out_imm_err=1

Behaviour:
- Reset (synchronous, rst=1 at posedge): out_valid=0, out_instr=0, out_imm_err=0, err_count=0, both stage-valid flags cleared. In-flight requests are dropped.
- Handshake:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - out_* is held stable while out_valid=1 and out_ready=0.
- Pipeline:
  - Stage A registers the raw fields.
  - Stage B registers the encoded word and error flag; it drives the out_* ports.
  - Latency: 2 cycles from input transfer to out_valid, with no stall.
  - Throughput: 1 per cycle. in_ready = !A_valid | !B_valid | out_ready.
  - Stage A advances to B when B is empty or B is transferring in the same cycle.
  - Simultaneous input accept and A→B advance in one cycle is legal.
- Encoding, opcode placed at [6:0] in every format:
  - R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7]
  - I: imm[11:0]→[31:20], rs1, funct3, rd
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7]
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7
  - U: imm[31:12]→[31:12], rd
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd
  - Fields unused by a format are ignored.
- Range check (out_imm_err=1 when violated):
  - I/S: in_imm must equal the sign-extension of in_imm[11:0].
  - B: in_imm[0]=0 and in_imm equals the sign-extension of in_imm[12:0].
  - J: in_imm[0]=0 and in_imm equals the sign-extension of in_imm[20:0].
  - U: in_imm[11:0]=0.
  - R: never an error.
  - fmt 6/7: out_instr=0 and out_imm_err=1.
  - On a range error the word is still produced from the truncated bits.
- err_count: increments on each output transfer with out_imm_err=1; saturates at 2^ERR_CNT_W-1 and does not wrap.

Optional Feature:
- Macro: INSTR_ENCODER_ERR_COUNT_EN
- Defined: err_count behaves as above.
- Undefined: no counter logic is built and err_count is tied to 0. out_imm_err is unaffected.

Test Plan:
- ADDI (fmt=1, opcode 0x13, rd=1, f3=0, rs1=0, imm=5), out_ready=1 → out_valid exactly 2 cycles after accept, out_instr=0x00500093, out_imm_err=0.
- Back-to-back SW (fmt=2, 0x23, f3=2, rs1=1, rs2=2, imm=8) then BEQ (fmt=3, 0x63, all regs 0, imm=-4) → out_instr 0x0020A423, then 0xFE000EE3 on consecutive cycles.
- JAL (fmt=5, 0x6F, rd=1, imm=0x800) → 0x001000EF. LUI (fmt=4, 0x37, rd=5, imm=0x12345000) → 0x123452B7.
- Errors: I imm=2048, B imm=3, U imm=0x00000001, fmt=7 → out_imm_err=1 on all four, fmt=7 word=0, err_count=4. With ERR_CNT_W=2 and a 5th error: err_count stays 3.
- Backpressure: hold out_ready=0 while streaming 3 requests → in_ready=0 after 2 accepted, out_* stable. Release out_ready → all 3 words delivered in order, no loss or duplication.
- Assert rst with both stages full → next cycle out_valid=0, err_count=0, in_ready=1; a new request encodes correctly 2 cycles later.
